hov_input_queue: RTL and testbench

Per-channel input stream buffer for the Hovalaag CPU. It sits directly downstream of the USB/EPP register interface. It captures the 12-bit input words the host commits via the `inputN_set`/`input_addr`/`input_data` lines, tracks how many words are loaded, and presents them to the CPU's IN port as a pop-on-request queue. It drives that interface's `inputN_rdy` status bit when the CPU is stalled on an empty queue. One instance per input channel (IN1, IN2).

---
 rtl/hov_input_queue.sv | 141 ++++++++++++++
 tb/tb_hov_input_queue.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hov_input_queue.sv
// Per-channel Hovalaag input stream buffer: host-filled RAM presented to the CPU IN port as a pop queue.
// Optional feature macro HOV_INPUT_LOOP_EN: replay the loaded stream cyclically instead of stalling at the end.
module hov_input_queue #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_set,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clear,
    input  logic              rewind,
    input  logic              rd_req,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              in_rdy,
    output logic [ADDR_W:0]   fill
);

    localparam int              DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_q_r;

    state_t            state_r, state_s;
    logic [ADDR_W:0]   rd_ptr_r, rd_ptr_s;
    logic [ADDR_W:0]   fill_r, fill_s;
    logic              rd_en_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic              ack_s;
    logic              rd_ack_r;
    logic [DATA_W-1:0] rd_data_r;
    logic              in_rdy_r;

    // Storage: write port from the host, registered read port for the CPU (read-before-write).
    always_ff @(posedge clk) begin
        if (in_set) begin
            mem[in_addr] <= in_data;
        end
        if (rd_en_s) begin
            ram_q_r <= mem[rd_addr_s];
        end
    end

    // Fill tracking and read FSM next-state; clear/rewind override any pop in progress.
    always_comb begin
        state_s   = state_r;
        rd_ptr_s  = rd_ptr_r;
        rd_en_s   = 1'b0;
        rd_addr_s = rd_ptr_r[ADDR_W-1:0];
        ack_s     = 1'b0;

        if (clear) begin
            fill_s = '0;
        end else if (in_set && ({1'b0, in_addr} >= fill_r)) begin
            fill_s = {1'b0, in_addr} + ONE;
        end else begin
            fill_s = fill_r;
        end

        if (clear || rewind) begin
            state_s  = ST_IDLE;
            rd_ptr_s = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rd_req && (rd_ptr_r < fill_r)) begin
                        state_s  = ST_READ;
                        rd_en_s  = 1'b1;
                        rd_ptr_s = rd_ptr_r + ONE;
`ifdef HOV_INPUT_LOOP_EN
                    end else if (rd_req && (fill_r != '0)) begin
                        // End of stream reached: replay from word 0.
                        state_s   = ST_READ;
                        rd_en_s   = 1'b1;
                        rd_addr_s = '0;
                        rd_ptr_s  = ONE;
`endif
                    end else if (rd_req) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_READ: begin
                    ack_s   = 1'b1;
                    state_s = ST_IDLE;
                end
                ST_WAIT: begin
                    if (!rd_req) begin
                        state_s = ST_IDLE;
                    end else if (rd_ptr_r < fill_r) begin
                        state_s  = ST_READ;
                        rd_en_s  = 1'b1;
                        rd_ptr_s = rd_ptr_r + ONE;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs; rd_data holds between acks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            rd_ptr_r  <= '0;
            fill_r    <= '0;
            rd_ack_r  <= 1'b0;
            rd_data_r <= '0;
            in_rdy_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            rd_ptr_r <= rd_ptr_s;
            fill_r   <= fill_s;
            rd_ack_r <= ack_s;
            in_rdy_r <= (state_s == ST_WAIT);
            if (ack_s) begin
                rd_data_r <= ram_q_r;
            end
        end
    end

    assign rd_ack  = rd_ack_r;
    assign rd_data = rd_data_r;
    assign in_rdy  = in_rdy_r;
    assign fill    = fill_r;

endmodule

// File: tb/tb_hov_input_queue.sv
// Bench for hov_input_queue: directed scenarios with literal expectations plus a randomized run,
// all checked every cycle against a queue-level behavioural model.
module tb_hov_input_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_set = 1'b0;
    logic [10:0] in_addr = 11'd0;
    logic [11:0] in_data = 12'd0;
    logic        clear = 1'b0;
    logic        rewind = 1'b0;
    logic        rd_req = 1'b0;
    logic        rd_ack;
    logic [11:0] rd_data;
    logic        in_rdy;
    logic [11:0] fill;

    int n_tests = 0;
    int n_fail  = 0;

    hov_input_queue dut (
        .clk(clk), .rst_n(rst_n), .in_set(in_set), .in_addr(in_addr), .in_data(in_data),
        .clear(clear), .rewind(rewind), .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data),
        .in_rdy(in_rdy), .fill(fill)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: loaded words, high-water mark, next word index, one pop in flight.
    int  m_mem [2048];
    bit  m_val [2048];
    int  m_fill, m_ptr, pop_val, e_data;
    bit  m_busy, m_wait, pop_known, e_ack, e_rdy, e_known;

    task automatic model_reset();
        m_fill = 0; m_ptr = 0; m_busy = 1'b0; m_wait = 1'b0;
        e_ack = 1'b0; e_rdy = 1'b0; e_data = 0; e_known = 1'b1;
        for (int i = 0; i < 2048; i++) m_val[i] = 1'b0;
    endtask

    task automatic model_step();
        bit ctl;
        int idx;
        ctl   = clear || rewind;
        e_ack = m_busy && !ctl;
        if (e_ack) begin
            e_data  = pop_val;
            e_known = pop_known;
        end
        if (ctl) begin
            m_ptr = 0; m_busy = 1'b0; m_wait = 1'b0;
        end else if (m_busy) begin
            m_busy = 1'b0;
        end else if (rd_req) begin
            idx = -1;
            if (m_ptr < m_fill) idx = m_ptr;
`ifdef HOV_INPUT_LOOP_EN
            else if (m_fill > 0) idx = 0;
`endif
            if (idx >= 0) begin
                pop_val = m_mem[idx]; pop_known = m_val[idx];
                m_ptr = idx + 1; m_busy = 1'b1; m_wait = 1'b0;
            end else begin
                m_wait = 1'b1;
            end
        end else begin
            m_wait = 1'b0;
        end
        e_rdy = m_wait;
        if (in_set) begin
            m_mem[in_addr] = int'(in_data);
            m_val[in_addr] = 1'b1;
        end
        if (clear) m_fill = 0;
        else if (in_set && int'(in_addr) >= m_fill) m_fill = int'(in_addr) + 1;
    endtask

    // Compare process: advance the model on each rising edge, check the DUT on the falling edge.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step();
            @(negedge clk);
            if (!rst_n) model_reset();
            check("cmp_rd_ack", int'(rd_ack), int'(e_ack));
            check("cmp_in_rdy", int'(in_rdy), int'(e_rdy));
            check("cmp_fill", int'(fill), m_fill);
            if (e_known) check("cmp_rd_data", int'(rd_data), e_data);
        end
    end

    task automatic wr(input int a, input int d);
        in_set = 1'b1; in_addr = 11'(a); in_data = 12'(d);
        @(negedge clk);
        in_set = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Pop one word: request at a falling edge, expect the ack two cycles later.
    task automatic pop(input string nm, output int data);
        int k;
        k = 0;
        rd_req = 1'b1;
        do begin
            @(negedge clk);
            k++;
        end while (!rd_ack && k < 40);
        rd_req = 1'b0;
        if (!rd_ack) check({nm, "_timeout"}, 0, 1);
        else check({nm, "_lat"}, k, 2);
        data = int'(rd_data);
    endtask

    int sw [2048];
    int d;
    int k;
    bit rdy_seen;

    initial begin
        #3000000;
        $display("[TB] watchdog expired at %0t", $time);
        $fatal(1, "simulation time limit");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_ack", int'(rd_ack), 0);
        check("reset_data", int'(rd_data), 0);
        check("reset_rdy", int'(in_rdy), 0);
        check("reset_fill", int'(fill), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Three words in, three pops out in order.
        wr(0, 12'h123); wr(1, 12'h456); wr(2, 12'h789);
        check("t1_fill", int'(fill), 3);
        pop("t1_pop0", d); check("t1_d0", d, 12'h123);
        pop("t1_pop1", d); check("t1_d1", d, 12'h456);
        pop("t1_pop2", d); check("t1_d2", d, 12'h789);

        // Request on empty queue, then a single host write releases it.
        pulse_clear();
        rd_req = 1'b1;
        @(negedge clk);
        check("t2_rdy_high", int'(in_rdy), 1);
        in_set = 1'b1; in_addr = 11'd0; in_data = 12'hABC;
        k = 0;
        do begin
            @(negedge clk);
            in_set = 1'b0;
            k++;
        end while (!rd_ack && k < 20);
        rd_req = 1'b0;
        check("t2_ack_cycle", k, 3);
        check("t2_data", int'(rd_data), 12'hABC);
        check("t2_rdy_low", int'(in_rdy), 0);

        // Full-depth auto-fill sweep.
        pulse_clear();
        for (int i = 0; i < 2048; i++) begin
            sw[i] = int'($urandom_range(0, 4095));
            in_set = 1'b1; in_addr = 11'(i); in_data = 12'(sw[i]);
            @(negedge clk);
        end
        in_set = 1'b0;
        check("t3_fill", int'(fill), 2048);
        for (int i = 0; i < 2048; i++) begin
            pop("t3_pop", d);
            check("t3_data", d, sw[i]);
        end
`ifdef HOV_INPUT_LOOP_EN
        pop("t3_wrap", d); check("t3_wrap_data", d, sw[0]);
`else
        rd_req = 1'b1;
        @(negedge clk);
        check("t3_end_wait", int'(in_rdy), 1);
        rd_req = 1'b0;
        @(negedge clk);
`endif

        // Clear aborts an in-flight read; clear beats a simultaneous write.
        pulse_clear();
        wr(0, 12'h111);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("t4_no_ack", int'(rd_ack), 0);
        check("t4_fill", int'(fill), 0);
        wr(0, 12'h5A5);
        pop("t4_pop", d); check("t4_ptr0", d, 12'h5A5);
        clear = 1'b1; in_set = 1'b1; in_addr = 11'd5; in_data = 12'h0F0;
        @(negedge clk);
        clear = 1'b0; in_set = 1'b0;
        check("t4_clear_set_fill", int'(fill), 0);

        // Rewind after two pops restarts at word 0.
        wr(0, 12'hA01); wr(1, 12'hA02); wr(2, 12'hA03);
        pop("t5_pop0", d); pop("t5_pop1", d);
        rewind = 1'b1;
        @(negedge clk);
        rewind = 1'b0;
        pop("t5_pop_rw", d); check("t5_word0", d, 12'hA01);
        check("t5_fill", int'(fill), 3);

        // Two-word stream: loop replays, one-shot stalls.
        pulse_clear();
        wr(0, 12'h0B0); wr(1, 12'h0B1);
        rdy_seen = 1'b0;
        pop("t6_pop0", d); check("t6_d0", d, 12'h0B0); rdy_seen |= in_rdy;
        pop("t6_pop1", d); check("t6_d1", d, 12'h0B1); rdy_seen |= in_rdy;
`ifdef HOV_INPUT_LOOP_EN
        pop("t6_pop2", d); check("t6_d2", d, 12'h0B0); rdy_seen |= in_rdy;
        pop("t6_pop3", d); check("t6_d3", d, 12'h0B1); rdy_seen |= in_rdy;
        check("t6_rdy_never", int'(rdy_seen), 0);
`else
        rd_req = 1'b1;
        @(negedge clk);
        check("t6_third_wait", int'(in_rdy), 1);
        rd_req = 1'b0;
        @(negedge clk);
`endif

        // Randomized traffic with a mid-run asynchronous reset.
        for (int c = 0; c < 3000; c++) begin
            in_set  = ($urandom_range(0, 9) < 3);
            in_addr = 11'($urandom_range(0, 20));
            in_data = 12'($urandom_range(0, 4095));
            clear   = ($urandom_range(0, 99) < 2);
            rewind  = ($urandom_range(0, 99) < 3);
            if (!rd_req) rd_req = ($urandom_range(0, 3) == 0);
            else if ($urandom_range(0, 7) == 0) rd_req = 1'b0;
            if (c == 1500) begin
                in_set = 1'b0; clear = 1'b0; rewind = 1'b0; rd_req = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                check("rnd_rst_ack", int'(rd_ack), 0);
                check("rnd_rst_fill", int'(fill), 0);
                check("rnd_rst_rdy", int'(in_rdy), 0);
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
            @(negedge clk);
        end
        in_set = 1'b0; clear = 1'b0; rewind = 1'b0; rd_req = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
